// File: rtl/mtr_pkg.sv
// Shared types and default constants for the motor speed slew limiter.
package mtr_pkg;

  typedef logic signed [11:0] spd_t;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    RUN   = 2'd1,
    STOP  = 2'd2,
    FAULT = 2'd3
  } ramp_state_t;

  localparam spd_t STEP_DEF     = 12'sd32;
  localparam spd_t MAX_SPD_DEF  = 12'sd2000;
  localparam spd_t DEADBAND_DEF = 12'sd24;

endpackage

// File: rtl/spd_slew.sv
// One channel of the slew limiter: saturate, optional deadband, step-limited next value.
// Deadband is compiled in only when SPD_DEADBAND_EN is defined.
module spd_slew
  import mtr_pkg::*;
#(
  parameter spd_t STEP     = STEP_DEF,
  parameter spd_t MAX_SPD  = MAX_SPD_DEF,
  parameter spd_t DEADBAND = DEADBAND_DEF
) (
  input  logic [11:0] tgt,
  input  logic [11:0] spd,
  input  logic        zero_tgt,
  output logic [11:0] tgt_sat,
  output logic [11:0] spd_nxt
);

`ifdef SPD_DEADBAND_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif

  localparam logic signed [12:0] STEP13 = 13'(STEP);

  spd_t              tgt_s;
  spd_t              spd_s;
  spd_t              clip;
  spd_t              lim;
  logic signed [12:0] diff;

  always_comb begin
    tgt_s = $signed(tgt);
    spd_s = $signed(spd);

    if (tgt_s > MAX_SPD)
      clip = MAX_SPD;
    else if (tgt_s < -MAX_SPD)
      clip = -MAX_SPD;
    else
      clip = tgt_s;

    if (zero_tgt || (DB_EN && (clip < DEADBAND) && (clip > -DEADBAND)))
      lim = '0;
    else
      lim = clip;

    // 13-bit difference so a full-scale reversal cannot wrap
    diff = $signed({lim[11], lim}) - $signed({spd_s[11], spd_s});

    if (diff > STEP13)
      spd_nxt = spd_s + STEP;
    else if (diff < -STEP13)
      spd_nxt = spd_s - STEP;
    else
      spd_nxt = lim;

    tgt_sat = lim;
  end

endmodule

// File: rtl/mtr_spd_ramp.sv
// Slew-rate limiter between balance controller and motor driver; forces zero drive on over-current.
// Optional target deadband enabled by defining SPD_DEADBAND_EN.
//
//   state | meaning
//   OFF   | outputs 0, prescaler held, waiting for en
//   RUN   | ramp each channel toward its saturated target once per tick
//   STOP  | ramp each channel toward 0 once per tick, OFF when both reach 0
//   FAULT | over-current seen, outputs forced 0 until rst
module mtr_spd_ramp
  import mtr_pkg::*;
#(
  parameter int   TICK_DIV = 2048,
  parameter spd_t STEP     = STEP_DEF,
  parameter spd_t MAX_SPD  = MAX_SPD_DEF,
  parameter spd_t DEADBAND = DEADBAND_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [11:0] lft_tgt,
  input  logic [11:0] rght_tgt,
  input  logic        OVR_I_shtdwn,
  output logic [11:0] lft_spd,
  output logic [11:0] rght_spd,
  output logic        at_tgt,
  output logic        fault
);

  localparam int             CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TICK_DIV - 1);

  ramp_state_t   state, state_nxt;
  logic [CW-1:0] pre_cnt;
  logic          active, active_nxt, tick, upd, zero_tgt;
  logic [11:0]   lft_nxt, rght_nxt, lft_sat, rght_sat, lft_d, rght_d;

  assign active     = (state == RUN) || (state == STOP);
  assign active_nxt = (state_nxt == RUN) || (state_nxt == STOP);
  assign tick       = active && (pre_cnt == CNT_LAST);
  assign zero_tgt   = (state == STOP);

  spd_slew #(.STEP(STEP), .MAX_SPD(MAX_SPD), .DEADBAND(DEADBAND)) u_slew_lft (
    .tgt      (lft_tgt),
    .spd      (lft_spd),
    .zero_tgt (zero_tgt),
    .tgt_sat  (lft_sat),
    .spd_nxt  (lft_nxt)
  );

  spd_slew #(.STEP(STEP), .MAX_SPD(MAX_SPD), .DEADBAND(DEADBAND)) u_slew_rght (
    .tgt      (rght_tgt),
    .spd      (rght_spd),
    .zero_tgt (zero_tgt),
    .tgt_sat  (rght_sat),
    .spd_nxt  (rght_nxt)
  );

  // An en change takes the edge; the tick update is skipped that cycle
  always_comb begin
    state_nxt = state;
    upd       = 1'b0;
    case (state)
      OFF:   if (en) state_nxt = RUN;
      RUN:   if (!en) state_nxt = STOP;
             else upd = tick;
      STOP:  if (en) state_nxt = RUN;
             else if ((lft_spd == '0) && (rght_spd == '0)) state_nxt = OFF;
             else upd = tick;
      FAULT: state_nxt = FAULT;
      default: state_nxt = OFF;
    endcase
    if (OVR_I_shtdwn) begin
      state_nxt = FAULT;
      upd       = 1'b0;
    end
  end

  always_comb begin
    lft_d  = lft_spd;
    rght_d = rght_spd;
    if (state_nxt == FAULT) begin
      lft_d  = '0;
      rght_d = '0;
    end else if (upd) begin
      lft_d  = lft_nxt;
      rght_d = rght_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= OFF;
      pre_cnt  <= '0;
      lft_spd  <= '0;
      rght_spd <= '0;
      at_tgt   <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state    <= state_nxt;
      lft_spd  <= lft_d;
      rght_spd <= rght_d;
      fault    <= (state_nxt == FAULT);
      at_tgt   <= (state_nxt == RUN) && (lft_d == lft_sat) && (rght_d == rght_sat);
      if (active && active_nxt)
        pre_cnt <= tick ? '0 : pre_cnt + CW'(1);
      else
        pre_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_mtr_spd_ramp.sv
// Directed bench for mtr_spd_ramp with a 16-clock update tick.
module tb_mtr_spd_ramp;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        ovr;
  logic [11:0] lft_tgt, rght_tgt;
  logic [11:0] lft_spd, rght_spd;
  logic        at_tgt, fault;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mtr_spd_ramp #(.TICK_DIV(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .lft_tgt      (lft_tgt),
    .rght_tgt     (rght_tgt),
    .OVR_I_shtdwn (ovr),
    .lft_spd      (lft_spd),
    .rght_spd     (rght_spd),
    .at_tgt       (at_tgt),
    .fault        (fault)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int lft_v();
    return int'($signed(lft_spd));
  endfunction

  function automatic int rght_v();
    return int'($signed(rght_spd));
  endfunction

  initial begin
    int exp;
    rst = 1'b1; en = 1'b0; ovr = 1'b0;
    lft_tgt = '0; rght_tgt = '0;
    clocks(3);
    chk("rst_lft", lft_v(), 0);
    chk("rst_rght", rght_v(), 0);
    chk("rst_at_tgt", int'(at_tgt), 0);
    chk("rst_fault", int'(fault), 0);
    rst = 1'b0;

    lft_tgt = 12'd400;
    clocks(20);
    chk("off_lft", lft_v(), 0);

    // enable: first update 16 clocks after entering RUN
    rght_tgt = -12'sd96;
    en = 1'b1;
    clocks(16);
    chk("pre_tick_lft", lft_v(), 0);
    clocks(1);
    chk("tick1_lft", lft_v(), 32);
    for (int k = 2; k <= 13; k++) begin
      clocks(16);
      exp = (32 * k > 400) ? 400 : 32 * k;
      chk($sformatf("up_lft_%0d", k), lft_v(), exp);
      if (k == 3)  chk("up_rght_3", rght_v(), -96);
      if (k == 12) chk("up_at_tgt_12", int'(at_tgt), 0);
    end
    chk("up_at_tgt_13", int'(at_tgt), 1);

    // reversal to -400
    lft_tgt = -12'sd400;
    for (int k = 1; k <= 25; k++) begin
      clocks(16);
      exp = 400 - 32 * k;
      if (exp < -400) exp = -400;
      chk($sformatf("rev_lft_%0d", k), lft_v(), exp);
    end
    chk("rev_at_tgt", int'(at_tgt), 1);

    // saturation at both extremes
    lft_tgt = 12'h7FF; rght_tgt = 12'h800;
    clocks(16 * 80);
    chk("sat_lft", lft_v(), 2000);
    chk("sat_rght", rght_v(), -2000);
    chk("sat_at_tgt", int'(at_tgt), 1);

    lft_tgt = 12'd400; rght_tgt = 12'd400;
    clocks(16 * 80);
    chk("back_lft", lft_v(), 400);
    chk("back_rght", rght_v(), 400);

    // stop: ramp to zero then OFF
    en = 1'b0;
    clocks(1);
    chk("stop_at_tgt", int'(at_tgt), 0);
    chk("stop_hold_lft", lft_v(), 400);
    clocks(15);
    chk("stop_lft_1", lft_v(), 368);
    for (int k = 2; k <= 13; k++) begin
      clocks(16);
      exp = 400 - 32 * k;
      if (exp < 0) exp = 0;
      chk($sformatf("stop_lft_%0d", k), lft_v(), exp);
    end
    chk("stop_rght", rght_v(), 0);
    clocks(2);

    // restart from OFF: prescaler starts from zero again
    en = 1'b1;
    clocks(16);
    chk("restart_pre_lft", lft_v(), 0);
    clocks(1);
    chk("restart_lft", lft_v(), 32);
    clocks(16 * 12);
    chk("restart_full_lft", lft_v(), 400);

    // resume mid-ramp-down
    en = 1'b0;
    clocks(16 * 6);
    chk("down_mid_lft", lft_v(), 208);
    en = 1'b1;
    clocks(16);
    chk("resume_lft", lft_v(), 240);
    chk("resume_rght", rght_v(), 240);
    chk("resume_at_tgt", int'(at_tgt), 0);

    // over-current fault
    ovr = 1'b1;
    clocks(1);
    chk("flt_lft", lft_v(), 0);
    chk("flt_rght", rght_v(), 0);
    chk("flt_fault", int'(fault), 1);
    chk("flt_at_tgt", int'(at_tgt), 0);
    ovr = 1'b0;
    en = 1'b0;
    clocks(20);
    en = 1'b1;
    clocks(40);
    chk("flt_sticky_lft", lft_v(), 0);
    chk("flt_sticky_fault", int'(fault), 1);

    // reset clears fault; small target for deadband behaviour
    lft_tgt = 12'd20; rght_tgt = -12'sd20;
    rst = 1'b1;
    clocks(1);
    chk("rst2_fault", int'(fault), 0);
    rst = 1'b0;
    clocks(17);
`ifdef SPD_DEADBAND_EN
    chk("db_lft", lft_v(), 0);
    chk("db_rght", rght_v(), 0);
`else
    chk("db_lft", lft_v(), 20);
    chk("db_rght", rght_v(), -20);
`endif
    chk("db_at_tgt", int'(at_tgt), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
